load_store_unit: RTL

- Memory stage directly downstream of the ALU.
- Takes the ALU's alu_result as the effective address and the rs2 operand as store data.
- Performs one RV32I byte/half/word load or store through a single-outstanding req/ready memory port.
- Returns sign- or zero-extended load data for writeback and holds the pipeline busy until the access completes.

---
 rtl/load_store_unit_pkg.sv | 36 +++
 rtl/load_store_unit_ls_align.sv | 68 ++++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared width codes, FSM encodings and access-legality helper for the
// load/store unit.
package load_store_unit_pkg;

  localparam int BYTE_LANES = 4;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_EXC  = 2'b11
  } ls_state_e;

  // True for reserved width codes, unsigned stores and misaligned H/W accesses.
  function automatic logic ls_access_bad(input logic is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic bad;
    case (funct3)
      LS_B:    bad = 1'b0;
      LS_H:    bad = offset[0];
      LS_W:    bad = (offset != 2'b00);
      LS_BU:   bad = is_store;
      LS_HU:   bad = is_store | offset[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_ls_align.sv
// Byte-lane steering: replicates store data, builds write strobes and
// extracts/extends the addressed lane of a read word.
module ls_align
  import load_store_unit_pkg::*;
#(
  parameter int OPERAND_LENGTH = 32
) (
  input  logic [2:0]                funct3,
  input  logic [1:0]                offset,
  input  logic [OPERAND_LENGTH-1:0] store_data,
  input  logic [OPERAND_LENGTH-1:0] rdata,
  output logic [OPERAND_LENGTH-1:0] wdata,
  output logic [BYTE_LANES-1:0]     wstrb,
  output logic [OPERAND_LENGTH-1:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: lane replication and strobe generation.
  always_comb begin
    wdata = store_data;
    wstrb = 4'b0000;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << offset;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << offset;
      end
      2'b10: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b0000;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend by width code.
  always_comb begin
    case (offset)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      LS_B:    load_data = {{24{byte_s[7]}}, byte_s};
      LS_H:    load_data = {{16{half_s[15]}}, half_s};
      LS_BU:   load_data = {24'h000000, byte_s};
      LS_HU:   load_data = {16'h0000, half_s};
      LS_W:    load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding RV32I byte/half/word load/store engine
// with registered memory-port and writeback outputs.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int OPERAND_LENGTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ls_start,
  input  logic                      ls_is_store,
  input  logic [2:0]                ls_funct3,
  input  logic [OPERAND_LENGTH-1:0] ls_addr,
  input  logic [OPERAND_LENGTH-1:0] ls_store_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [OPERAND_LENGTH-1:0] mem_addr,
  output logic [OPERAND_LENGTH-1:0] mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_ready,
  input  logic [OPERAND_LENGTH-1:0] mem_rdata,
  output logic                      ls_busy,
  output logic                      ls_done,
  output logic [OPERAND_LENGTH-1:0] ls_load_data,
  output logic                      ls_exc
);

  ls_state_e                 state_r, state_nxt_s;
  logic [2:0]                funct3_r;
  logic [1:0]                offset_r;
  logic                      bad_s, accept_s;
  logic [2:0]                align_f3_s;
  logic [1:0]                align_off_s;
  logic [OPERAND_LENGTH-1:0] align_wdata_s, align_load_s;
  logic [BYTE_LANES-1:0]     align_wstrb_s;

  assign bad_s = ls_access_bad(ls_is_store, ls_funct3, ls_addr[1:0]);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ls_start) begin
          accept_s = 1'b1;
          if (bad_s) begin
            state_nxt_s = ST_EXC;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_EXC:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // In IDLE the aligner formats the incoming store; afterwards it decodes
  // the read word using the latched width and offset.
  always_comb begin
    if (state_r == ST_IDLE) begin
      align_f3_s  = ls_funct3;
      align_off_s = ls_addr[1:0];
    end else begin
      align_f3_s  = funct3_r;
      align_off_s = offset_r;
    end
  end

  ls_align #(.OPERAND_LENGTH(OPERAND_LENGTH)) u_align (
    .funct3     (align_f3_s),
    .offset     (align_off_s),
    .store_data (ls_store_data),
    .rdata      (mem_rdata),
    .wdata      (align_wdata_s),
    .wstrb      (align_wstrb_s),
    .load_data  (align_load_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs, all derived from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= 4'b0000;
      ls_busy      <= 1'b0;
      ls_done      <= 1'b0;
      ls_exc       <= 1'b0;
      ls_load_data <= '0;
      funct3_r     <= 3'b000;
      offset_r     <= 2'b00;
    end else begin
      mem_req <= (state_nxt_s == ST_REQ);
      ls_busy <= (state_nxt_s != ST_IDLE);
      ls_done <= (state_nxt_s == ST_DONE) || (state_nxt_s == ST_EXC);
      ls_exc  <= (state_nxt_s == ST_EXC);
      if (accept_s && !bad_s) begin
        funct3_r  <= ls_funct3;
        offset_r  <= ls_addr[1:0];
        mem_addr  <= {ls_addr[OPERAND_LENGTH-1:2], 2'b00};
        mem_we    <= ls_is_store;
        mem_wdata <= align_wdata_s;
        mem_wstrb <= ls_is_store ? align_wstrb_s : 4'b0000;
      end
      if ((state_r == ST_REQ) && mem_ready && !mem_we) begin
        ls_load_data <= align_load_s;
      end
    end
  end

endmodule
